tpi_irq_ctrl: RTL and testbench
===============================

Name: tpi_irq_ctrl

Overview:
- Parametrised successor to the TPI interrupt logic: NIRQ edge-triggered interrupt lines, per-line mask and edge polarity, and an optional priority mode with a nesting stack of parametrised depth.
- Provides end-of-interrupt (EOI) pop and overflow flagging, which the fixed 5-line TPI lacks.
- Sits on the 6509-side CPU register bus beside the TPI/CIA blocks.
- Drives one active-high irq into the system interrupt combiner.

Parameters:
- NIRQ, 5, number of interrupt lines (1..8).
- DEPTH, 5, priority nesting stack entries (1..8).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- res  in  1  synchronous reset, active-high
- cs_n  in  1  chip select, active-low; one clk per bus access
- rw  in  1  1 = read, 0 = write
- rs  in  3  register select
- db_in  in  8  write data
- db_out  out  8  registered read data
- irq_in  in  NIRQ  raw interrupt lines
- irq  out  1  interrupt request, = |AIR

Behaviour:
- rd = !cs_n & rw; wr = !cs_n & !rw. Side effects occur on every clk where rd/wr is true.
- db_out: loaded on a rd cycle and valid the next clk; holds otherwise. Reset value 0.
- Registers (bit i = line i; unused high bits read 0, writes ignored):
  - 0 ILR, latched requests. Read returns ILR. Write: ILR &= db_in.
  - 1 IMR, mask (1 = enabled). Read/write.
  - 2 EPR, edge polarity (1 = rising, 0 = falling). Read/write.
  - 3 CR: bit0 IP (priority mode), bit1 EN. Read/write. Other bits read 0.
  - 4 AIR, active interrupt. Read returns AIR, then acknowledges. Write (any data) = EOI.
  - 5 STAT: {OVF, 3'b0, depth[3:0]}. Read clears OVF.
  - 6, 7: read 0, writes ignored.
- Edge detect:
  - irq_in is registered each clk into prev.
  - Line i edge = (irq_in[i]^~EPR[i]) & !(prev[i]^~EPR[i]).
  - Edge sets ILR[i] only while EN=1.
  - An edge and a ILR clear/ack on the same bit in the same cycle: the set wins.
- intreq = ILR & IMR.
- Non-priority mode (IP=0):
  - If AIR==0 and intreq!=0, AIR <= intreq, one cycle later.
  - AIR read: ILR &= ~AIR, AIR <= 0.
  - AIR write: no effect.
- Priority mode (IP=1):
  - act = AIR | OR of all stack entries.
  - msk = all bits strictly above the highest set bit of act; all ones if act==0.
  - If intreq & msk != 0, AIR <= one-hot of the highest set bit. This may replace a lower AIR that has not yet been acknowledged.
  - AIR read: push AIR onto the stack, depth++. Then ILR &= ~AIR, AIR <= 0. A push of AIR==0 is not performed.
  - Stack full on push: entry dropped, depth unchanged, OVF <= 1.
  - AIR write (EOI): pop the top entry, depth--. Pop when empty: no-op.
  - Read and EOI never coincide, since there is one access per clk.
- Mode changes:
  - Write to CR changing IP: stack cleared, depth=0, AIR=0, OVF unchanged.
  - EN=0: ILR, AIR and stack are held (not cleared); new edges are ignored.
- Reset: ILR, IMR, EPR, CR, AIR, stack, depth, OVF, prev and db_out all 0; irq=0. Reset mid-nesting discards the stack.
- Latency: edge at irq_in to irq = 3 clk (prev register, ILR, AIR).

Decomposition:
- Package tpi_pkg: register address constants (TPI_ILR..TPI_STAT), CR bit indices, and function prio_onehot(vec) returning the highest-set-bit one-hot.
- Sub-module tpi_prio_stack (params W=NIRQ, DEPTH):
  - Inputs: push, pop, clr, din.
  - Outputs: or_all, depth, full, empty.
  - A register array with a shift-based push/pop.

Test Plan:
- Reset, then read all regs -> every read 0, irq=0.
- IMR=0x1F, EPR=0, CR=0x02, falling edge on line 2 -> ILR=0x04, AIR=0x04, irq=1 three clk after the edge. Read AIR -> 0x04, then ILR=0, irq=0.
- Non-priority: lines 0 and 3 fall in the same clk -> AIR=0x09. Read clears both.
- Priority, CR=0x03:
  - Line 1 -> AIR=0x02. Ack -> depth=1.
  - Line 0 -> no irq (masked by nesting).
  - Line 4 -> AIR=0x10. Ack -> depth=2.
  - EOI x2 -> depth=0, then AIR=0x01.
- DEPTH=2, three nested acks (lines 2, 3, 4) -> depth=2, STAT=0x82. Reading STAT clears OVF -> 0x02.
- Write ILR=0x00 in the same clk as a line-0 edge -> ILR bit0 ends at 1.
- EPR=0x01: a rising edge on line 0 sets ILR; a falling edge does not.

Source files
------------

// File: rtl/tpi_irq_ctrl_pkg.sv
// Shared definitions for the TPI interrupt controller: register map,
// control-bit positions and priority helper functions.
package tpi_pkg;

  typedef enum logic [2:0] {
    TPI_ILR  = 3'd0,
    TPI_IMR  = 3'd1,
    TPI_EPR  = 3'd2,
    TPI_CR   = 3'd3,
    TPI_AIR  = 3'd4,
    TPI_STAT = 3'd5
  } tpi_reg_e;

  localparam int CR_IP = 0;
  localparam int CR_EN = 1;

  function automatic logic [7:0] prio_onehot(input logic [7:0] vec);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) res = 8'(1 << i);
    end
    return res;
  endfunction

  // Bits strictly above the highest set bit of act; all ones when act is empty.
  function automatic logic [7:0] prio_above_mask(input logic [7:0] act);
    logic [7:0] hb;
    hb = prio_onehot(act);
    if (act == '0) return 8'hFF;
    return ~(hb | (hb - 8'd1));
  endfunction

endpackage

// File: rtl/tpi_irq_ctrl_if.sv
// CPU register bus as seen by the interrupt controller.
interface tpi_irq_ctrl_if;
  logic       cs_n;
  logic       rw;
  logic [2:0] rs;
  logic [7:0] db_in;
  logic [7:0] db_out;

  modport master (output cs_n, rw, rs, db_in, input db_out);
  modport slave  (input cs_n, rw, rs, db_in, output db_out);
endinterface

// File: rtl/tpi_irq_ctrl_prio_stack.sv
// Priority nesting stack: entry 0 is the top, push/pop shift the whole array.
module tpi_prio_stack #(
  parameter int W     = 5,
  parameter int DEPTH = 5
) (
  input  logic         clk,
  input  logic         res,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] or_all,
  output logic [3:0]   depth,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [DEPTH];
  logic [3:0]   r_depth;
  logic [W-1:0] w_up  [DEPTH];
  logic [W-1:0] w_dn  [DEPTH];
  logic         w_full;
  logic         w_empty;

  assign w_full  = (r_depth == 4'(DEPTH));
  assign w_empty = (r_depth == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_top
        assign w_up[gi] = din;
      end else begin : g_mid
        assign w_up[gi] = r_mem[gi-1];
      end
      // Vacated bottom entries are zeroed so or_all needs no depth qualifier.
      if (gi == DEPTH-1) begin : g_bot
        assign w_dn[gi] = '0;
      end else begin : g_low
        assign w_dn[gi] = r_mem[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res || clr) begin
      r_depth <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (push && !w_full) begin
      r_mem   <= w_up;
      r_depth <= r_depth + 4'd1;
    end else if (pop && !w_empty) begin
      r_mem   <= w_dn;
      r_depth <= r_depth - 4'd1;
    end
  end

  always_comb begin
    or_all = '0;
    for (int k = 0; k < DEPTH; k++) or_all = or_all | r_mem[k];
  end

  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: rtl/tpi_irq_ctrl.sv
// Edge-triggered interrupt controller with mask, polarity, and optional
// priority nesting with EOI; register file on the CPU bus.
module tpi_irq_ctrl
  import tpi_pkg::*;
#(
  parameter int NIRQ  = 5,
  parameter int DEPTH = 5
) (
  input  logic            clk,
  input  logic            res,
  tpi_irq_ctrl_if.slave   bus,
  input  logic [NIRQ-1:0] irq_in,
  output logic            irq
);

  logic [NIRQ-1:0] r_in, r_prev, r_ilr, r_imr, r_epr, r_air;
  logic [1:0]      r_cr;
  logic            r_ovf;
  logic [7:0]      r_db_out;

  logic            w_rd, w_wr, w_ip, w_en;
  logic            w_ack, w_eoi, w_ip_chg, w_push, w_pop;
  logic [NIRQ-1:0] w_edge, w_intreq, w_act, w_msk, w_sel, w_stk_or;
  logic [NIRQ-1:0] w_ilr_nxt, w_air_nxt;
  logic [3:0]      w_depth;
  logic            w_full, w_empty;
  logic [7:0]      w_rd_data;
  logic            w_unused_db;

  assign w_rd = !bus.cs_n && bus.rw;
  assign w_wr = !bus.cs_n && !bus.rw;
  assign w_ip = r_cr[CR_IP];
  assign w_en = r_cr[CR_EN];
  assign w_unused_db = ^bus.db_in;

  // r_in is the sampling stage; edges compare it against the previous sample.
  assign w_edge   = (r_in ~^ r_epr) & ~(r_prev ~^ r_epr);
  assign w_intreq = r_ilr & r_imr;

  assign w_ack    = w_rd && (bus.rs == TPI_AIR);
  assign w_eoi    = w_wr && (bus.rs == TPI_AIR);
  assign w_ip_chg = w_wr && (bus.rs == TPI_CR) && (bus.db_in[CR_IP] != w_ip);
  assign w_push   = w_ack && w_ip && (r_air != '0);
  assign w_pop    = w_eoi && w_ip && !w_empty;

  assign w_act = r_air | w_stk_or;
  assign w_msk = NIRQ'(prio_above_mask(8'(w_act)));
  assign w_sel = NIRQ'(prio_onehot(8'(w_intreq & w_msk)));

  tpi_prio_stack #(.W(NIRQ), .DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .res    (res),
    .push   (w_push),
    .pop    (w_pop),
    .clr    (w_ip_chg),
    .din    (r_air),
    .or_all (w_stk_or),
    .depth  (w_depth),
    .full   (w_full),
    .empty  (w_empty)
  );

  // A fresh edge overrides a same-cycle clear or acknowledge of that bit.
  always_comb begin
    w_ilr_nxt = r_ilr;
    if (w_wr && (bus.rs == TPI_ILR)) w_ilr_nxt = r_ilr & bus.db_in[NIRQ-1:0];
    if (w_ack) w_ilr_nxt = w_ilr_nxt & ~r_air;
    if (w_en) w_ilr_nxt = w_ilr_nxt | w_edge;
  end

  always_comb begin
    w_air_nxt = r_air;
    if (w_ip_chg || w_ack) begin
      w_air_nxt = '0;
    end else if (w_en) begin
      if (w_ip) begin
        if ((w_intreq & w_msk) != '0) w_air_nxt = w_sel;
      end else if ((r_air == '0) && (w_intreq != '0)) begin
        w_air_nxt = w_intreq;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.rs)
      TPI_ILR:  w_rd_data = 8'(r_ilr);
      TPI_IMR:  w_rd_data = 8'(r_imr);
      TPI_EPR:  w_rd_data = 8'(r_epr);
      TPI_CR:   w_rd_data = {6'b0, r_cr};
      TPI_AIR:  w_rd_data = 8'(r_air);
      TPI_STAT: w_rd_data = {r_ovf, 3'b0, w_depth};
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_in     <= '0;
      r_prev   <= '0;
      r_ilr    <= '0;
      r_imr    <= '0;
      r_epr    <= '0;
      r_cr     <= '0;
      r_air    <= '0;
      r_ovf    <= 1'b0;
      r_db_out <= '0;
    end else begin
      r_in   <= irq_in;
      r_prev <= r_in;
      r_ilr  <= w_ilr_nxt;
      r_air  <= w_air_nxt;
      if (w_rd) r_db_out <= w_rd_data;
      if (w_wr && (bus.rs == TPI_IMR)) r_imr <= bus.db_in[NIRQ-1:0];
      if (w_wr && (bus.rs == TPI_EPR)) r_epr <= bus.db_in[NIRQ-1:0];
      if (w_wr && (bus.rs == TPI_CR))  r_cr  <= bus.db_in[1:0];
      if (w_rd && (bus.rs == TPI_STAT)) r_ovf <= 1'b0;
      else if (w_push && w_full)        r_ovf <= 1'b1;
    end
  end

  assign bus.db_out = r_db_out;
  assign irq        = |r_air;

endmodule

// File: tb/tb_tpi_irq_ctrl.sv
// Directed bench for tpi_irq_ctrl (NIRQ=5, DEPTH=2 so overflow is reachable).
module tb_tpi_irq_ctrl;
  import tpi_pkg::*;

  logic       clk;
  logic       res;
  logic [4:0] irq_in;
  logic       irq;
  int         n_checks;
  int         n_errors;
  logic [7:0] rd;

  tpi_irq_ctrl_if bus_if ();

  tpi_irq_ctrl #(.NIRQ(5), .DEPTH(2)) dut (
    .clk    (clk),
    .res    (res),
    .bus    (bus_if.slave),
    .irq_in (irq_in),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    bus_if.cs_n  = 1'b0;
    bus_if.rw    = 1'b0;
    bus_if.rs    = a;
    bus_if.db_in = d;
    tick(1);
    bus_if.cs_n  = 1'b1;
    bus_if.rw    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    bus_if.cs_n = 1'b0;
    bus_if.rw   = 1'b1;
    bus_if.rs   = a;
    tick(1);
    bus_if.cs_n = 1'b1;
    d = bus_if.db_out;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  // One-cycle low pulse on the selected lines, then wait for it to reach AIR.
  task automatic pulse_fall(input logic [4:0] m);
    irq_in = irq_in & ~m;
    tick(1);
    irq_in = irq_in | m;
    tick(3);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    res          = 1'b1;
    irq_in       = 5'h1F;
    bus_if.cs_n  = 1'b1;
    bus_if.rw    = 1'b1;
    bus_if.rs    = 3'd0;
    bus_if.db_in = 8'h00;
    tick(3);
    res = 1'b0;

    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_dbout", bus_if.db_out, 8'h00);
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 8'h00, $sformatf("rst_reg%0d", i));

    // Basic falling edge on line 2 and its latency
    bus_wr(TPI_IMR, 8'h1F);
    bus_wr(TPI_EPR, 8'h00);
    bus_wr(TPI_CR,  8'h02);
    irq_in[2] = 1'b0;
    tick(1);
    check("lat_clk1", {7'b0, irq}, 8'h00);
    tick(1);
    check("lat_clk2", {7'b0, irq}, 8'h00);
    tick(1);
    check("lat_clk3", {7'b0, irq}, 8'h01);
    irq_in[2] = 1'b1;
    rd_chk(TPI_ILR, 8'h04, "l2_ilr");
    rd_chk(TPI_AIR, 8'h04, "l2_air");
    check("l2_irq_ack", {7'b0, irq}, 8'h00);
    rd_chk(TPI_ILR, 8'h00, "l2_ilr_ack");

    // Non-priority: two simultaneous lines
    pulse_fall(5'h09);
    check("np_irq", {7'b0, irq}, 8'h01);
    rd_chk(TPI_AIR, 8'h09, "np_air");
    rd_chk(TPI_ILR, 8'h00, "np_ilr");
    check("np_irq_ack", {7'b0, irq}, 8'h00);

    // Priority nesting
    bus_wr(TPI_CR, 8'h03);
    rd_chk(TPI_CR, 8'h03, "cr_rd");
    pulse_fall(5'h02);
    rd_chk(TPI_AIR, 8'h02, "pr_air_l1");
    rd_chk(TPI_STAT, 8'h01, "pr_depth1");
    pulse_fall(5'h01);
    check("pr_l0_masked", {7'b0, irq}, 8'h00);
    rd_chk(TPI_ILR, 8'h01, "pr_l0_latched");
    pulse_fall(5'h10);
    check("pr_l4_irq", {7'b0, irq}, 8'h01);
    rd_chk(TPI_AIR, 8'h10, "pr_air_l4");
    rd_chk(TPI_STAT, 8'h02, "pr_depth2");
    bus_wr(TPI_AIR, 8'h00);
    rd_chk(TPI_STAT, 8'h01, "pr_eoi1");
    check("pr_eoi1_irq", {7'b0, irq}, 8'h00);
    bus_wr(TPI_AIR, 8'h00);
    rd_chk(TPI_STAT, 8'h00, "pr_eoi2");
    check("pr_eoi2_irq", {7'b0, irq}, 8'h01);
    rd_chk(TPI_AIR, 8'h01, "pr_air_l0");

    // Overflow of the 2-entry stack
    bus_wr(TPI_CR, 8'h02);
    bus_wr(TPI_CR, 8'h03);
    rd_chk(TPI_STAT, 8'h00, "ov_clr");
    pulse_fall(5'h04);
    rd_chk(TPI_AIR, 8'h04, "ov_air2");
    pulse_fall(5'h08);
    rd_chk(TPI_AIR, 8'h08, "ov_air3");
    pulse_fall(5'h10);
    rd_chk(TPI_AIR, 8'h10, "ov_air4");
    rd_chk(TPI_STAT, 8'h82, "ov_stat");
    rd_chk(TPI_STAT, 8'h02, "ov_stat_clr");

    // Edge beats a same-cycle ILR clear
    bus_wr(TPI_IMR, 8'h00);
    irq_in[0] = 1'b0;
    tick(1);
    irq_in[0] = 1'b1;
    bus_wr(TPI_ILR, 8'h00);
    rd_chk(TPI_ILR, 8'h01, "set_wins");
    bus_wr(TPI_ILR, 8'h00);
    rd_chk(TPI_ILR, 8'h00, "ilr_clear");

    // Rising polarity on line 0
    bus_wr(TPI_EPR, 8'h01);
    rd_chk(TPI_EPR, 8'h01, "epr_rd");
    irq_in[0] = 1'b0;
    tick(3);
    rd_chk(TPI_ILR, 8'h00, "rise_nofall");
    irq_in[0] = 1'b1;
    tick(3);
    rd_chk(TPI_ILR, 8'h01, "rise_set");

    rd_chk(3'd6, 8'h00, "reg6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
